// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, single-outstanding memory fetch, prefetch queue and branch redirect
// feeding the decoder through a valid/ready handshake.
module instruction_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [15:0] mem_data_i,
    output logic [15:0] instr_o,
    output logic [15:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        branch_taken_i,
    input  logic [15:0] branch_target_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT, DISCARD} state_e;

    state_e         state_q, state_d;
    logic [15:0]    pc_q, pc_d, addr_q, addr_d;
    logic           req_q, req_d;
    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic [15:0]    instr_q [DEPTH];
    logic [15:0]    ipc_q [DEPTH];
    logic           push, pop, free;

    assign instr_valid_o = cnt_q != '0;
    assign instr_o       = instr_valid_o ? instr_q[rptr_q] : 16'h0;
    assign instr_pc_o    = instr_valid_o ? ipc_q[rptr_q] : 16'h0;
    assign mem_req_o     = req_q;
    assign mem_addr_o    = addr_q;

    // A redirect overrides both the ack push and the decoder pop of the same cycle.
    assign push   = state_q == WAIT && mem_ack_i && !branch_taken_i;
    assign pop    = instr_valid_o && instr_ready_i && !branch_taken_i;
    assign cnt_d  = branch_taken_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign wptr_d = branch_taken_i ? '0 : wptr_q + AW'(push);
    assign rptr_d = branch_taken_i ? '0 : rptr_q + AW'(pop);
    assign free   = cnt_d < FULL;

    // While DISCARD waits for the stale ack, pc_q holds the latched redirect target.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        case (state_q)
            RUN: if (branch_taken_i || free) begin
                pc_d    = branch_taken_i ? branch_target_i : pc_q;
                req_d   = 1'b1;
                addr_d  = pc_d;
                state_d = WAIT;
            end
            WAIT: if (mem_ack_i) begin
                pc_d    = branch_taken_i ? branch_target_i : pc_q + 16'd1;
                req_d   = branch_taken_i || free;
                addr_d  = pc_d;
                state_d = req_d ? WAIT : RUN;
            end else if (branch_taken_i) begin
                pc_d    = branch_target_i;
                state_d = DISCARD;
            end
            DISCARD: if (mem_ack_i) begin
                pc_d    = branch_taken_i ? branch_target_i : pc_q;
                addr_d  = pc_d;
                state_d = WAIT;
            end else if (branch_taken_i) begin
                pc_d    = branch_target_i;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wptr_q] <= mem_data_i;
            ipc_q[wptr_q]   <= addr_q;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && !pop && cnt_q == FULL));
endmodule
